// File: rtl/fir_sequencer_if.sv
// Signal bundle for fir_sequencer: sample input, coefficient writes, external MAC and result output.
// The slave modport is the sequencer; the master modport is the host plus the MAC.
interface fir_sequencer_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_sample;
  logic           coef_we;
  logic [AW-1:0]  coef_addr;
  logic [W-1:0]   coef_data;
  logic [W-1:0]   mac_a;
  logic [W-1:0]   mac_b;
  logic           acc_load;
  logic [2*W-1:0] acc_out;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
  logic           busy;

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data, acc_out, out_ready,
    input  in_ready, mac_a, mac_b, acc_load, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data, acc_out, out_ready,
    output in_ready, mac_a, mac_b, acc_load, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_sequencer.sv
// TAPS-tap direct-form FIR that sequences an external multiplier/accumulator pair.
// Optional FIR_SEQ_COEF_LOCK_EN: coefficient writes only land while the sequencer is idle.
module fir_sequencer #(
  parameter int W    = 8,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic           i_clk,
  input  logic           i_clear,
  fir_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [AW-1:0]  r_k;
  logic [AW-1:0]  r_wp;
  logic [AW-1:0]  r_newest;
  logic [W-1:0]   r_buf  [TAPS];
  logic [W-1:0]   r_coef [TAPS];
  logic [2*W-1:0] r_out_data;

  logic           w_accept;
  logic           w_coef_wr;
  logic [AW-1:0]  w_rd_idx;
  logic           w_last_tap;
  logic           w_in_ready;
  logic           w_busy;
  logic           w_acc_load;
  logic           w_out_valid;
  logic [W-1:0]   w_mac_a;
  logic [W-1:0]   w_mac_b;

  assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
`ifdef FIR_SEQ_COEF_LOCK_EN
  assign w_coef_wr  = bus.coef_we && (r_state == S_IDLE);
`else
  assign w_coef_wr  = bus.coef_we;
`endif
  // TAPS is a power of two, so the AW-bit subtraction is the modular history index.
  assign w_rd_idx   = r_newest - r_k;
  assign w_last_tap = (r_k == AW'(TAPS - 1));

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      for (int i = 0; i < TAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_wp       <= '0;
      r_newest   <= '0;
      r_k        <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_buf[r_wp] <= bus.in_sample;
        r_newest    <= r_wp;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_coef_wr) begin
        r_coef[bus.coef_addr] <= bus.coef_data;
      end
      if (r_state == S_PRIME) begin
        r_k <= '0;
      end else if (r_state == S_RUN) begin
        r_k <= r_k + AW'(1);
      end
      if (r_state == S_DONE) begin
        r_out_data <= bus.acc_out;
      end
    end
  end

  // Handshake flags and MAC operands decode from registered state only.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b1;
    w_acc_load   = 1'b0;
    w_out_valid  = 1'b0;
    w_mac_a      = '0;
    w_mac_b      = '0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          w_next_state = S_PRIME;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_PRIME: begin
        w_acc_load   = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_mac_a = r_buf[w_rd_idx];
        w_mac_b = r_coef[r_k];
        if (w_last_tap) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        w_next_state = S_OUT;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_OUT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.acc_load  = w_acc_load;
  assign bus.out_valid = w_out_valid;
  assign bus.mac_a     = w_mac_a;
  assign bus.mac_b     = w_mac_b;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer at TAPS=4: external MAC model, history-based reference, directed plus random traffic.
module tb_fir_sequencer;
  localparam int W    = 8;
  localparam int TAPS = 4;
  localparam int AW   = 2;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  fir_sequencer_if #(.W(W), .AW(AW)) bus ();

  fir_sequencer #(.W(W), .TAPS(TAPS), .AW(AW)) dut (
    .i_clk   (clk),
    .i_clear (clear),
    .bus     (bus)
  );

  // External multiplier/accumulator: the only state outside the sequencer.
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] prod;
  assign prod        = {8'd0, bus.mac_a} * {8'd0, bus.mac_b};
  assign bus.acc_out = acc_r;
  always @(posedge clk or posedge clear) begin
    if (clear) acc_r <= '0;
    else if (bus.acc_load) acc_r <= prod;
    else acc_r <= acc_r + prod;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: coefficient table and sample history, index 0 = newest sample.
  logic [W-1:0]   m_coef [TAPS];
  logic [W-1:0]   m_hist [TAPS];
  logic [2*W-1:0] exp_q [$];

  function automatic logic [2*W-1:0] ref_sum();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(m_coef[k]) * longint'(m_hist[k]);
    return s[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = '0;
      m_hist[k] = '0;
    end
    exp_q.delete();
  endtask

  task automatic coef_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
    tick();
    bus.coef_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic send(input logic [W-1:0] s, input bit cw, input logic [AW-1:0] ca,
                      input logic [W-1:0] cd, input bit push);
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_sample = s;
    if (cw) begin
      bus.coef_we = 1'b1; bus.coef_addr = ca; bus.coef_data = cd;
    end
    tick();
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    if (cw) m_coef[ca] = cd;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    if (push) exp_q.push_back(ref_sum());
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (bus.in_ready) done = 1'b1;
    end
    bus.out_ready = 1'b1;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: got in_ready=0 after %0d cycles expected 1", budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_acc_load"},  32'(bus.acc_load),  32'd0);
    chk({tag, "_mac_a"},     32'(bus.mac_a),     32'd0);
    chk({tag, "_mac_b"},     32'(bus.mac_b),     32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] e;
    logic [2*W-1:0] od;
    logic [2*W-1:0] ao;
    logic [W-1:0]   cval;
    longint         s;
    int             pulses;
    bit             seen;

    clear = 1'b1;
    bus.in_valid = 1'b0; bus.in_sample = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Monitor: pops the scoreboard on every output handshake.
    fork
      forever begin
        @(negedge clk);
        if (!clear && bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected: got %0d expected none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out_data", 32'(bus.out_data), 32'(e));
          end
        end
      end
    join_none

    tick(); tick();
    chk_reset_outputs("por");
    clear = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Impulse response
    coef_write(2'd0, 8'd1); coef_write(2'd1, 8'd2); coef_write(2'd2, 8'd3); coef_write(2'd3, 8'd4);
    send(8'd1, 1'b0, '0, '0, 1'b1);
    // Latency of the first run
    chk("lat_acc_load_c1", 32'(bus.acc_load), 32'd1);
    chk("lat_busy_c1", 32'(bus.busy), 32'd1);
    chk("lat_in_ready_c1", 32'(bus.in_ready), 32'd0);
    chk("lat_mac_a_c1", 32'(bus.mac_a), 32'd0);
    tick();
    chk("lat_acc_load_c2", 32'(bus.acc_load), 32'd0);
    chk("lat_tap0_a", 32'(bus.mac_a), 32'd1);
    chk("lat_tap0_b", 32'(bus.mac_b), 32'd1);
    tick(); tick(); tick(); tick();
    chk("lat_out_valid_c6", 32'(bus.out_valid), 32'd0);
    chk("lat_mac_b_done", 32'(bus.mac_b), 32'd0);
    tick();
    chk("lat_out_valid_c7", 32'(bus.out_valid), 32'd1);
    tick();
    chk("lat_in_ready_c8", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(8'd0, 1'b0, '0, '0, 1'b1);
      wait_idle(40, 1'b0);
    end

    // Wrap of the 16-bit sum
    for (int k = 0; k < TAPS; k++) coef_write(AW'(k), 8'd255);
    for (int i = 0; i < 4; i++) begin
      send(8'd255, 1'b0, '0, '0, 1'b1);
      wait_idle(40, 1'b0);
    end
    chk("wrap_out_data", 32'(bus.out_data), 32'd63492);

    // Backpressure
    bus.out_ready = 1'b0;
    send(8'($urandom), 1'b0, '0, '0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_out_valid_seen", 32'(seen), 32'd1);
    od = bus.out_data;
    ao = bus.acc_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_data_stable", 32'(bus.out_data), 32'(od));
      chk("bp_acc_stable", 32'(bus.acc_out), 32'(ao));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_mac_ab", 32'({bus.mac_a, bus.mac_b}), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);

    // Reset during tap 2
    send(8'd77, 1'b0, '0, '0, 1'b0);
    tick(); tick(); tick();
    chk("rst_pre_busy", 32'(bus.busy), 32'd1);
    clear = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    tick();
    clear = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("rst_no_out_valid", 32'(pulses), 32'd0);
    coef_write(2'd0, 8'd1);
    send(8'd5, 1'b0, '0, '0, 1'b1);
    wait_idle(40, 1'b0);
    chk("rst_then_5", 32'(bus.out_data), 32'd5);

    // Coefficient write during tap 1
    for (int k = 0; k < TAPS; k++) coef_write(AW'(k), 8'd1);
    for (int i = 0; i < 3; i++) begin
      send(8'd1, 1'b0, '0, '0, 1'b1);
      wait_idle(40, 1'b0);
    end
    send(8'd1, 1'b0, '0, '0, 1'b0);
    tick(); tick();
    bus.coef_we = 1'b1; bus.coef_addr = 2'd3; bus.coef_data = 8'd9;
    tick();
    bus.coef_we = 1'b0;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
`ifdef FIR_SEQ_COEF_LOCK_EN
      cval = m_coef[k];
`else
      cval = (k > 1 && k == 3) ? 8'd9 : m_coef[k];
`endif
      s += longint'(cval) * longint'(m_hist[k]);
    end
    exp_q.push_back(s[2*W-1:0]);
`ifndef FIR_SEQ_COEF_LOCK_EN
    m_coef[3] = 8'd9;
`endif
    wait_idle(40, 1'b0);
`ifdef FIR_SEQ_COEF_LOCK_EN
    chk("midrun_result", 32'(bus.out_data), 32'd4);
`else
    chk("midrun_result", 32'(bus.out_data), 32'd12);
`endif
    send(8'd2, 1'b0, '0, '0, 1'b1);
    wait_idle(40, 1'b0);

    // Random traffic with same-cycle coefficient writes and random backpressure
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) coef_write(AW'($urandom_range(0, 3)), W'($urandom));
      send(W'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), W'($urandom), 1'b1);
      wait_idle(80, 1'b1);
    end

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

- Sequences the shared multiplier/accumulator pair as a TAPS-tap direct-form FIR filter.
- Accepts one sample per valid/ready handshake and stores it in an internal circular delay line.
- Walks every tap through the MAC, then presents the registered sum on a valid/ready output.
- Owns the coefficient register file (host-writable) and the sample history; the external multiplier and accumulator hold no state of their own beyond `acc_out`.

## Interface

- `W`, 8, sample and coefficient width (unsigned)
- `TAPS`, 8, filter length; power of two, ≥2
- `AW`, 3, log2(TAPS)

Ports:

- `clk`  in  1  clock, rising-edge
- `clear`  in  1  reset, asynchronous, active-high; same net as the accumulator's `clear`
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  sample accepted when `in_valid && in_ready` at a rising edge
- `in_sample`  in  W  new sample
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  AW  coefficient index
- `coef_data`  in  W  coefficient value
- `mac_a`  out  W  multiplier operand: sample
- `mac_b`  out  W  multiplier operand: coefficient
- `acc_load`  out  1  accumulator restart; the next accumulated product adds to 0
- `acc_out`  in  2W  accumulator result
- `out_valid`  out  1  filter result available
- `out_ready`  in  1  result consumed when `out_valid && out_ready` at a rising edge
- `out_data`  out  2W  filter result
- `busy`  out  1  high in every state except IDLE

## Operation

States are IDLE, PRIME, RUN, DONE and OUT.

- **IDLE**
  - `in_ready`=1.
  - On accept, write `in_sample` to `buf[wp]`, set `newest`=`wp`, advance `wp`=(`wp`+1) mod TAPS, and go to PRIME.
- **PRIME** (1 cycle)
  - `acc_load`=1 and `mac_a`=`mac_b`=0.
  - Go to RUN with tap counter k=0.
- **RUN** (TAPS cycles)
  - `mac_a`=`buf[(newest−k) mod TAPS]` and `mac_b`=`coef[k]`; `acc_load`=0.
  - k increments each cycle. When k=TAPS−1, go to DONE.
- **DONE** (1 cycle)
  - `mac_a`=`mac_b`=0, so the accumulator holds its value.
  - `out_data`<=`acc_out`; go to OUT.
- **OUT**
  - `out_valid`=1 and `mac_a`=`mac_b`=0.
  - `out_data` stays stable until the handshake. On handshake go to IDLE.

Outside RUN, `mac_a` and `mac_b` are 0 in all states, so the accumulator never drifts.

Arithmetic and state:
- All arithmetic is unsigned. Products are 2W bits and the sum wraps mod 2^(2W); there is no saturation.
- `buf` is cleared to 0 by `clear`, so the first TAPS−1 outputs see zero history.
- `coef` is cleared to 0 by `clear`.
- `wp` is cleared to 0 by `clear`.

Coefficient writes:
- A coefficient write takes effect at the rising edge where `coef_we`=1.
- A write in the same IDLE cycle as a sample accept is used by that sample's run.
- A RUN read of the address being written in that cycle returns the old value.

Reset:
- `clear` at any point forces IDLE and clears `buf`, `coef`, `wp`, k and `out_data`.
- Any run in flight is discarded and no `out_valid` pulse occurs.

Reset output values: `in_ready`=1, `busy`=0, `acc_load`=0, `mac_a`=`mac_b`=0, `out_valid`=0, `out_data`=0.

## Timing

- Sample accepted at the edge ending cycle 0:
  - PRIME in cycle 1, with `acc_load` high in cycle 1 only.
  - Tap k on `mac_a`/`mac_b` in cycle 2+k.
  - DONE in cycle TAPS+2.
  - `out_valid` first high in cycle TAPS+3 (cycle 11 at default TAPS).
- Throughput is one sample per TAPS+4 cycles when `out_ready` is held high.
- `in_ready` is 0 from cycle 1 until the cycle after the output handshake.
- `in_ready`, `out_valid`, `busy`, `acc_load`, `mac_a` and `mac_b` decode from registered state and counters only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration

- `FIR_SEQ_COEF_LOCK_EN` defined: `coef_we` is ignored whenever `busy`=1; only IDLE writes land.
- `FIR_SEQ_COEF_LOCK_EN` undefined: writes land in any state, including mid-RUN; a later tap in the same run sees the new value.

## Test plan

All scenarios use TAPS=4, AW=2, W=8.

- **Impulse response:** coefs {1,2,3,4}; samples 1,0,0,0,0 → `out_data` 1,2,3,4,0.
- **Wrap:** all coefs 255; four samples of 255 → fourth `out_data` = 260100 mod 65536 = 63492.
- **Latency:** accept at cycle 0 → `acc_load` high in cycle 1 only; `out_valid` rises in cycle 7.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with `out_valid` high → `out_data` stable, `in_ready`=0, `mac_a`=`mac_b`=0, `acc_out` unchanged; release → handshake and `in_ready`=1 next cycle.
- **Reset mid-RUN:** pulse `clear` during tap 2 → all outputs at reset values immediately and `out_valid` never pulses. Then coef {1,0,0,0} and sample 5 → `out_data`=5.
- **Mid-RUN coefficient write:** write coef[3]=9 during tap 1 of a run with samples {1,1,1,1} and coefs {1,1,1,1}.
  - With `FIR_SEQ_COEF_LOCK_EN`: result 4 and coef[3] stays 1.
  - Without it: result 12.
